// File: rtl/lfsr_seq_checker_if.sv
// Sample stream and status bundle between an LFSR sample source and lfsr_seq_checker.
// LFSR_CHK_BITERR_EN adds the bit_err_count status field.
interface lfsr_seq_checker_if #(
  parameter int ERR_W = 16
);
  logic [23:0]      sample_in;
  logic             sample_valid;
  logic             clear_stats;
  logic             locked;
  logic             match;
  logic             mismatch;
  logic             lost;
  logic [ERR_W-1:0] err_count;
`ifdef LFSR_CHK_BITERR_EN
  logic [31:0]      bit_err_count;
`endif

  modport master (
    output sample_in, sample_valid, clear_stats,
`ifdef LFSR_CHK_BITERR_EN
    input  bit_err_count,
`endif
    input  locked, match, mismatch, lost, err_count
  );

  modport slave (
    input  sample_in, sample_valid, clear_stats,
`ifdef LFSR_CHK_BITERR_EN
    output bit_err_count,
`endif
    output locked, match, mismatch, lost, err_count
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 24-bit LFSR noise stream: locks, then flags and counts departures.
// Optional LFSR_CHK_BITERR_EN adds a saturating count of wrong bits seen while locked.
module lfsr_seq_checker #(
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  lfsr_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  function automatic logic [23:0] adv_n(input logic [23:0] s);
    logic [23:0] r;
    r = s;
    for (int i = 0; i < STEP; i++) r = {r[22:0], r[23] ^ r[22]};
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [23:0]      pred_q, pred_d;
  logic [7:0]       good_q, good_d;
  logic [7:0]       bad_q, bad_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             match_q, match_d;
  logic             mismatch_q, mismatch_d;
  logic             lost_q, lost_d;
  logic             nonzero;
  logic             hit;
  logic [8:0]       good_inc;
  logic [8:0]       bad_inc;
`ifdef LFSR_CHK_BITERR_EN
  logic [31:0]      bit_err_q, bit_err_d;
  logic [5:0]       pop;
  logic [32:0]      bit_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      pred_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      err_q      <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      lost_q     <= 1'b0;
`ifdef LFSR_CHK_BITERR_EN
      bit_err_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pred_q     <= pred_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      lost_q     <= lost_d;
`ifdef LFSR_CHK_BITERR_EN
      bit_err_q  <= bit_err_d;
`endif
    end
  end

  // All-zero is the LFSR's stuck state, so it never counts as a correct prediction.
  always_comb begin
    state_d    = state_q;
    pred_d     = pred_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_d      = err_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    lost_d     = 1'b0;
    nonzero    = (bus.sample_in != 24'h000000);
    hit        = nonzero && (bus.sample_in == pred_q);
    good_inc   = {1'b0, good_q} + 9'd1;
    bad_inc    = {1'b0, bad_q} + 9'd1;
`ifdef LFSR_CHK_BITERR_EN
    bit_err_d  = bit_err_q;
    pop        = 6'($countones(bus.sample_in ^ pred_q));
    bit_sum    = {1'b0, bit_err_q} + {27'd0, pop};
`endif

    if (bus.sample_valid) begin
      case (state_q)
        SEARCH: begin
          if (nonzero) begin
            pred_d  = adv_n(bus.sample_in);
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            match_d = 1'b1;
            pred_d  = adv_n(bus.sample_in);
            good_d  = good_inc[7:0];
            if (good_inc == 9'(LOCK_COUNT)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            mismatch_d = 1'b1;
            good_d     = '0;
            if (nonzero) pred_d = adv_n(bus.sample_in);
            else         state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (hit) begin
            match_d = 1'b1;
            bad_d   = '0;
            pred_d  = adv_n(bus.sample_in);
          end else begin
            // Flywheel on our own prediction so a corrupt sample cannot knock us off sequence.
            mismatch_d = 1'b1;
            pred_d     = adv_n(pred_q);
            bad_d      = bad_inc[7:0];
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
`ifdef LFSR_CHK_BITERR_EN
            bit_err_d = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
`endif
            if (bad_inc == 9'(LOSS_COUNT)) begin
              state_d = SEARCH;
              lost_d  = 1'b1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (bus.clear_stats) begin
      err_d = '0;
`ifdef LFSR_CHK_BITERR_EN
      bit_err_d = '0;
`endif
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.match     = match_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.lost      = lost_q;
  assign bus.err_count = err_q;
`ifdef LFSR_CHK_BITERR_EN
  assign bus.bit_err_count = bit_err_q;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: three parameterisations share one stimulus stream and are
// compared against a behavioural model; directed tables cover lock, loss, wrap and saturation.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        clear_stats = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lfsr_seq_checker_if #(.ERR_W(16)) if0 ();
  lfsr_seq_checker_if #(.ERR_W(16)) if1 ();
  lfsr_seq_checker_if #(.ERR_W(4))  if2 ();

  assign if0.sample_in = sample_in;  assign if0.sample_valid = sample_valid;  assign if0.clear_stats = clear_stats;
  assign if1.sample_in = sample_in;  assign if1.sample_valid = sample_valid;  assign if1.clear_stats = clear_stats;
  assign if2.sample_in = sample_in;  assign if2.sample_valid = sample_valid;  assign if2.clear_stats = clear_stats;

  lfsr_seq_checker #(.STEP(1), .LOCK_COUNT(4), .LOSS_COUNT(3),   .ERR_W(16)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  lfsr_seq_checker #(.STEP(3), .LOCK_COUNT(1), .LOSS_COUNT(1),   .ERR_W(16)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  lfsr_seq_checker #(.STEP(1), .LOCK_COUNT(4), .LOSS_COUNT(255), .ERR_W(4))  dut2 (.clk(clk), .reset(reset), .bus(if2));

  // Behavioural model: one record of bookkeeping per instance, driven by the observed sample stream.
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;
  int          p_step[3]   = '{1, 3, 1};
  int          p_lock[3]   = '{4, 1, 4};
  int          p_loss[3]   = '{3, 1, 255};
  longint      p_errmax[3] = '{65535, 65535, 15};
  int          m_mode[3];
  logic [23:0] m_pred[3];
  int          m_good[3], m_bad[3];
  longint      m_err[3], m_biterr[3];
  bit          m_match[3], m_mismatch[3], m_lost[3];

  function automatic logic [23:0] lfsr_next(input logic [23:0] s, input int n);
    logic [23:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {r[22:0], r[23] ^ r[22]};
    return r;
  endfunction

  task automatic model_step(input int k, input bit r, input bit v, input logic [23:0] s, input bit c);
    bit hit;
    m_match[k] = 0; m_mismatch[k] = 0; m_lost[k] = 0;
    if (r) begin
      m_mode[k] = M_SEARCH; m_pred[k] = '0; m_good[k] = 0; m_bad[k] = 0; m_err[k] = 0; m_biterr[k] = 0;
      return;
    end
    if (v) begin
      hit = (s != 0) && (s == m_pred[k]);
      if (m_mode[k] == M_SEARCH) begin
        if (s != 0) begin m_pred[k] = lfsr_next(s, p_step[k]); m_good[k] = 0; m_mode[k] = M_VERIFY; end
      end else if (m_mode[k] == M_VERIFY) begin
        if (hit) begin
          m_match[k] = 1; m_pred[k] = lfsr_next(s, p_step[k]); m_good[k]++;
          if (m_good[k] == p_lock[k]) begin m_mode[k] = M_LOCKED; m_bad[k] = 0; end
        end else begin
          m_mismatch[k] = 1; m_good[k] = 0;
          if (s != 0) m_pred[k] = lfsr_next(s, p_step[k]);
          else        m_mode[k] = M_SEARCH;
        end
      end else begin
        if (hit) begin
          m_match[k] = 1; m_bad[k] = 0; m_pred[k] = lfsr_next(s, p_step[k]);
        end else begin
          m_mismatch[k] = 1;
          m_err[k]    = (m_err[k] + 1 > p_errmax[k]) ? p_errmax[k] : m_err[k] + 1;
          m_biterr[k] = m_biterr[k] + $countones(s ^ m_pred[k]);
          if (m_biterr[k] > 64'hFFFF_FFFF) m_biterr[k] = 64'hFFFF_FFFF;
          m_pred[k] = lfsr_next(m_pred[k], p_step[k]);
          m_bad[k]++;
          if (m_bad[k] == p_loss[k]) begin m_mode[k] = M_SEARCH; m_lost[k] = 1; end
        end
      end
    end
    if (c) begin m_err[k] = 0; m_biterr[k] = 0; end
  endtask

  function automatic logic [3:0] dut_flags(input int k);
    case (k)
      0:       return {if0.locked, if0.match, if0.mismatch, if0.lost};
      1:       return {if1.locked, if1.match, if1.mismatch, if1.lost};
      default: return {if2.locked, if2.match, if2.mismatch, if2.lost};
    endcase
  endfunction

  function automatic logic [32:0] dut_err(input int k);
    case (k)
      0:       return {17'd0, if0.err_count};
      1:       return {17'd0, if1.err_count};
      default: return {29'd0, if2.err_count};
    endcase
  endfunction

`ifdef LFSR_CHK_BITERR_EN
  function automatic logic [32:0] dut_biterr(input int k);
    case (k)
      0:       return {1'b0, if0.bit_err_count};
      1:       return {1'b0, if1.bit_err_count};
      default: return {1'b0, if2.bit_err_count};
    endcase
  endfunction
`endif

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [23:0] s, input bit c);
    reset = r; sample_valid = v; sample_in = s; clear_stats = c;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) model_step(k, r, v, s, c);
    reset = 1'b0; sample_valid = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic checkOutput(input int k, input string tag);
    logic [3:0] f;
    f = dut_flags(k);
    check($sformatf("%s dut%0d locked", tag, k),   {32'd0, f[3]}, {32'd0, m_mode[k] == M_LOCKED});
    check($sformatf("%s dut%0d match", tag, k),    {32'd0, f[2]}, {32'd0, m_match[k]});
    check($sformatf("%s dut%0d mismatch", tag, k), {32'd0, f[1]}, {32'd0, m_mismatch[k]});
    check($sformatf("%s dut%0d lost", tag, k),     {32'd0, f[0]}, {32'd0, m_lost[k]});
    check($sformatf("%s dut%0d err_count", tag, k), dut_err(k), 33'(m_err[k]));
`ifdef LFSR_CHK_BITERR_EN
    check($sformatf("%s dut%0d bit_err_count", tag, k), dut_biterr(k), 33'(m_biterr[k]));
`endif
  endtask

  task automatic checkAll(input string tag);
    for (int k = 0; k < 3; k++) checkOutput(k, tag);
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    logic [23:0] s;
    bit          clr;
    bit          e_locked, e_match, e_mismatch, e_lost;
    int          e_err;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, logic [23:0] s, bit c, bit l, bit m, bit mm, bit lo, int e);
    vec_t t;
    t.rst = r; t.v = v; t.s = s; t.clr = c;
    t.e_locked = l; t.e_match = m; t.e_mismatch = mm; t.e_lost = lo; t.e_err = e;
    return t;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [3:0]  f;
    logic [23:0] tx, s;
    int          seg_step, r;

    // Expected values below are for dut0 (STEP=1, LOCK_COUNT=4, LOSS_COUNT=3).
    vecs.push_back(mk(1, 0, 24'h000000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000002, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000004, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000008, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000010, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 24'h000000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h123456, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 24'h000040, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 24'h000000, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 24'h111111, 0, 1, 0, 1, 0, 2));
    vecs.push_back(mk(0, 1, 24'h222222, 0, 1, 0, 1, 0, 3));
    vecs.push_back(mk(0, 1, 24'h333333, 0, 0, 0, 1, 1, 4));
    vecs.push_back(mk(0, 1, 24'h000000, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 24'h000001, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 24'h000000, 0, 0, 0, 1, 0, 4));
    vecs.push_back(mk(0, 1, 24'h000001, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 24'h000002, 0, 0, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 24'h000004, 0, 0, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 24'h000008, 0, 0, 1, 0, 0, 4));
    vecs.push_back(mk(0, 1, 24'h000010, 0, 1, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 24'h000000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000020, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h555555, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 24'h000000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h800000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000001, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 24'h000000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'hC00000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h800000, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000001, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000002, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000004, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 24'h000008, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000008, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 24'h000010, 0, 0, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].clr);
      f = dut_flags(0);
      check($sformatf("vec%0d locked", i),    {32'd0, f[3]}, {32'd0, vecs[i].e_locked});
      check($sformatf("vec%0d match", i),     {32'd0, f[2]}, {32'd0, vecs[i].e_match});
      check($sformatf("vec%0d mismatch", i),  {32'd0, f[1]}, {32'd0, vecs[i].e_mismatch});
      check($sformatf("vec%0d lost", i),      {32'd0, f[0]}, {32'd0, vecs[i].e_lost});
      check($sformatf("vec%0d err_count", i), dut_err(0), 33'(vecs[i].e_err));
      checkAll($sformatf("vec%0d", i));
    end

    // STEP=3 with single-sample lock and single-miss loss on dut1.
    applyStimulus(1, 0, 24'h0, 0);
    applyStimulus(0, 1, 24'h000001, 0);
    applyStimulus(0, 1, 24'h000008, 0);
    f = dut_flags(1);
    check("step3 match", {32'd0, f[2]}, 33'd1);
    check("step3 lock1 locked", {32'd0, f[3]}, 33'd1);
    applyStimulus(0, 1, 24'h123456, 0);
    f = dut_flags(1);
    check("loss1 lost", {32'd0, f[0]}, 33'd1);
    check("loss1 locked", {32'd0, f[3]}, 33'd0);
    check("loss1 err_count", dut_err(1), 33'd1);
    applyStimulus(0, 1, 24'h800000, 0);
    applyStimulus(0, 1, 24'h000004, 0);
    f = dut_flags(1);
    check("step3 wrap match", {32'd0, f[2]}, 33'd1);
    checkAll("step3");

    // Saturation and clear on dut2 (ERR_W=4, LOSS_COUNT=255).
    applyStimulus(1, 0, 24'h0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 24'h000001 << i, 0);
    f = dut_flags(2);
    check("sat lock locked", {32'd0, f[3]}, 33'd1);
    applyStimulus(0, 1, 24'h0000E0, 0);
    check("sat first err_count", dut_err(2), 33'd1);
`ifdef LFSR_CHK_BITERR_EN
    check("biterr popcount", dut_biterr(2), 33'd2);
`endif
    checkAll("sat first");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(0, 1, 24'h123456, 0);
      checkAll($sformatf("sat%0d", i));
    end
    f = dut_flags(2);
    check("sat err_count", dut_err(2), 33'd15);
    check("sat locked", {32'd0, f[3]}, 33'd1);
    applyStimulus(0, 1, 24'h123456, 1);
    f = dut_flags(2);
    check("sat clear err_count", dut_err(2), 33'd0);
    check("sat clear mismatch", {32'd0, f[1]}, 33'd1);
    checkAll("sat clear");

    // Randomised stream: mostly correct continuations with corruption, zeros, gaps, clears and resets.
    tx = 24'h000001;
    seg_step = 1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 99) < 2) seg_step = int'($urandom_range(1, 3));
      if (r < 15) begin
        applyStimulus($urandom_range(0, 99) == 0, 0, 24'($urandom), $urandom_range(0, 99) < 3);
      end else begin
        tx = lfsr_next(tx, seg_step);
        if      (r < 75) s = tx;
        else if (r < 85) s = 24'($urandom);
        else if (r < 90) s = 24'h000000;
        else             s = tx ^ (24'h000001 << $urandom_range(0, 23));
        applyStimulus($urandom_range(0, 199) == 0, 1, s, $urandom_range(0, 99) < 3);
      end
      checkAll($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
